// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: scoreboard entry
// layout, the regfile select code and the select-width function.
package fwd_pkg;

    // Scoreboard dst field is sized for the widest register index supported.
    localparam int SB_DST_W   = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                wen;
        logic                load;
    } sb_entry_t;

    function automatic int fwdSelWidth(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Per-source EX operand selector: regfile value for select 0, otherwise the
// result of the stage named by the select.
module fwd_operand_mux
    import fwd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FWD_DEPTH = 2,
    parameter int SW        = 2
) (
    input  logic [SW-1:0]               sel,
    input  logic [DATA_W-1:0]           rfVal,
    input  logic [FWD_DEPTH*DATA_W-1:0] stageVal,
    output logic [DATA_W-1:0]           operand
);

    always_comb begin
        operand = rfVal;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (sel == SW'(k + 1)) begin
                operand = stageVal[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with an in-flight destination scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall / forward-event counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int REG_AW    = 5,
    parameter int DATA_W    = 32,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    localparam int SW       = fwdSelWidth(FWD_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_reg,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_dst_reg,
    input  logic                        id_reg_write,
    input  logic                        id_mem_read,
    input  logic                        flush,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_val,
    input  logic [FWD_DEPTH*DATA_W-1:0] stage_val,
    output logic                        stall,
    output logic [NUM_SRC*SW-1:0]       ex_fwd_sel,
`ifdef HAZARD_PERF_EN
    output logic [31:0]                 perf_stall_cycles,
    output logic [31:0]                 perf_fwd_events,
`endif
    output logic [NUM_SRC*DATA_W-1:0]   ex_operand
);

    function automatic int availOf(input logic isLoad);
        return isLoad ? 1 + LOAD_LAT : 1;
    endfunction

    sb_entry_t                    sb [FWD_DEPTH];
    logic [NUM_SRC-1:0][SW-1:0]   selP0;
    logic [NUM_SRC-1:0][SW-1:0]   selP1;
    logic [NUM_SRC-1:0]           hazP0;
    logic [SB_DST_W-1:0]          srcIdx;
    logic                         hit;
    logic                         enterP0;

    // ---- ID: youngest matching producer decides; an unready one stalls ----
    always_comb begin
        selP0  = '0;
        hazP0  = '0;
        srcIdx = '0;
        hit    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            srcIdx = SB_DST_W'(id_src_reg[i*REG_AW +: REG_AW]);
            hit    = 1'b0;
            if (id_src_used[i] && srcIdx != '0) begin
                for (int k = 0; k < FWD_DEPTH; k++) begin
                    if (!hit && sb[k].valid && sb[k].wen && sb[k].dst == srcIdx) begin
                        hit = 1'b1;
                        if (k + 1 >= availOf(sb[k].load)) selP0[i] = SW'(k + 1);
                        else                               hazP0[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall   = id_valid & ~flush & (|hazP0);
    assign enterP0 = id_valid & ~stall & ~flush;

    // ---- ID -> EX: scoreboard shift and registered selects ----
    always_ff @(posedge clk) begin
        sb[0].dst  <= SB_DST_W'(id_dst_reg);
        sb[0].wen  <= id_reg_write;
        sb[0].load <= id_mem_read;
        for (int k = 1; k < FWD_DEPTH; k++) sb[k] <= sb[k-1];
        if (reset) begin
            for (int k = 0; k < FWD_DEPTH; k++) sb[k].valid <= 1'b0;
            selP1 <= {NUM_SRC{SW'(FWD_SEL_RF)}};
        end else begin
            sb[0].valid <= enterP0;
            selP1       <= enterP0 ? selP0 : {NUM_SRC{SW'(FWD_SEL_RF)}};
        end
    end

    assign ex_fwd_sel = selP1;

    // ---- EX: operand muxes driven by the registered selects ----
    for (genvar i = 0; i < NUM_SRC; i++) begin : gMux
        fwd_operand_mux #(
            .DATA_W   (DATA_W),
            .FWD_DEPTH(FWD_DEPTH),
            .SW       (SW)
        ) uMux (
            .sel     (selP1[i]),
            .rfVal   (ex_rf_val[i*DATA_W +: DATA_W]),
            .stageVal(stage_val),
            .operand (ex_operand[i*DATA_W +: DATA_W])
        );
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    logic [31:0] fwdCnt;

    always_comb begin
        fwdCnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (selP0[i] != '0) fwdCnt = fwdCnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_fwd_events   <= '0;
        end else begin
            perf_stall_cycles <= satAdd(perf_stall_cycles, {31'b0, stall});
            perf_fwd_events   <= satAdd(perf_fwd_events, enterP0 ? fwdCnt : 32'd0);
        end
    end
`endif

endmodule
